mul_sequencer: RTL and testbench
================================

Name: mul_sequencer

Overview:
- Multi-cycle controller for the H6 shift-add multiplier. It sequences the MUL1 (load), MUL2 (iterate) and MUL3 (flag/result) phases.
- Drives the H6 A/Q register strobes.
- Stalls the main control unit while the multiply runs.
- Asserts MUL3 for exactly one cycle so PSW flag logic samples H6_a_out/H6_q_out.
- Sits between the instruction-decode/control FSM and the H6 datapath.

Parameters:
- WIDTH, 16: operand width; number of iteration cycles.
- CNT_W, 5: iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  MUL decoded in EX0; sampled only in IDLE.
- abort  in  1  flush request (interrupt/pipeline flush); highest priority.
- q0  in  1  H6_q_out[0], current multiplier LSB.
- h6_load  out  1  load A<=0, Q<=multiplier, M<=multiplicand, C<=0.
- h6_add  out  1  A<=A+M this cycle (carry into C).
- h6_shift  out  1  shift {C,A,Q} right one bit this cycle.
- MUL1  out  1  load phase indicator.
- MUL2  out  1  iterate phase indicator.
- MUL3  out  1  flag/result phase indicator; feeds PSW flag logic.
- busy  out  1  stall to control FSM; high from the cycle after start through MUL3.
- done  out  1  one-cycle pulse, coincident with MUL3.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, counter=0. All outputs 0.
- States: IDLE, LOAD, ITER, FLAG.
- State transitions:
  - IDLE -> LOAD when start & ~abort.
  - LOAD -> ITER, counter <= WIDTH-1.
  - ITER: while counter != 0, counter decrements; at counter==0 go to FLAG.
  - FLAG -> IDLE.
- Phase outputs are Moore decodes of state:
  - MUL1 = LOAD.
  - MUL2 = ITER.
  - MUL3 = done = FLAG.
  - busy = any state except IDLE.
- h6_load = LOAD.
- h6_shift = ITER.
- h6_add = ITER & q0. This is Mealy, combinational from q0; add and shift happen in the same cycle, and H6 computes the shift from the sum.
- Latency: start high at edge t gives LOAD in cycle t+1, ITER in cycles t+2..t+WIDTH+1, FLAG in cycle t+WIDTH+2, IDLE at t+WIDTH+3. busy is high for WIDTH+2 cycles (18 at default).
- start while busy: ignored; no queuing.
- start held high continuously: a new multiply begins on the first IDLE cycle after FLAG. There is one dead IDLE cycle minimum between multiplies.
- abort in any non-IDLE state: next state IDLE, counter cleared, no FLAG cycle, MUL3/done never pulse. Strobes drop on the next edge.
- abort & start together in IDLE: abort wins; the block stays IDLE.
- Reset mid-operation: immediate return to IDLE with all outputs 0; H6 contents are don't-care.
- Counter never wraps; it is only loaded in LOAD and decremented in ITER.

Optional Feature:
- Macro: MUL_SIGNED_BOOTH_EN.
- When defined:
  - Adds an output h6_sub (A<=A-M) and an internal q_m1 register, cleared in LOAD and set to q0 on each ITER cycle.
  - Radix-2 Booth recoding: {q0,q_m1}=10 gives h6_sub; 01 gives h6_add; 00/11 give shift only.
  - h6_shift becomes arithmetic (A[15] replicated); an extra output h6_arith is held high.
  - Timing is unchanged.
- When undefined:
  - Unsigned shift-add as above.
  - No h6_sub, h6_arith or q_m1.

Decomposition:
- Shared include mul_seq_defs.vh holds the state encoding localparams (IDLE=2'd0, LOAD=2'd1, ITER=2'd2, FLAG=2'd3) and the default WIDTH/CNT_W.
- One sub-module, mul_iter_counter: load/decrement counter with zero flag.
- The FSM and strobe decode stay in mul_sequencer.

Test Plan:
- Reset then idle: rst_n low mid-cycle -> all outputs 0 asynchronously; start=0 for 10 cycles -> busy stays 0.
- 3*5 unsigned with behavioural H6 model: pulse start -> MUL1 for 1 cycle; MUL2 for 16 cycles; h6_add high only on ITER cycles 0 and 2 (q0=1, 0, 1, then 0); MUL3=done for 1 cycle; A=0x0000, Q=0x000F; busy high for exactly 18 cycles.
- 0xFFFF*0xFFFF -> h6_add high all 16 ITER cycles; at MUL3, A=0xFFFE, Q=0x0001.
- abort on the 5th ITER cycle -> IDLE next cycle; MUL3/done never asserted; a subsequent start runs a full 18-cycle multiply.
- start asserted during busy and together with abort in IDLE -> no extra multiply launched; busy count unchanged.
- With MUL_SIGNED_BOOTH_EN: (-3)*5 (0xFFFD*0x0005) -> h6_sub/h6_add pattern follows Booth pairs; result {A,Q}=0xFFFF_FFF1 at MUL3.

Source files
------------

// File: rtl/mul_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// mul_sequencer_pkg
// Shared definitions for the H6 multiply sequencer: the state encoding and the
// default operand/counter widths. Imported by mul_sequencer and its counter.
// No ports.
// -----------------------------------------------------------------------------
package mul_sequencer_pkg;

   localparam int unsigned DEF_WIDTH = 16;  // operand width = iteration count
   localparam int unsigned DEF_CNT_W = 5;   // must satisfy 2**CNT_W > WIDTH

   // Encoding is fixed so debug probes on the state bits read consistently.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      ITER = 2'd2,
      FLAG = 2'd3
   } state_e;

endpackage

// File: rtl/mul_iter_counter.sv
// -----------------------------------------------------------------------------
// mul_iter_counter
// Iteration counter for the multiply sequencer. Loaded once per multiply,
// decremented once per iterate cycle, and never wraps below zero.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clr_i        synchronous clear (abort); highest priority
//   load_i       load load_val_i
//   load_val_i   value to load (WIDTH-1)
//   dec_i        decrement request; ignored when already zero
//   zero_o       counter is zero
// -----------------------------------------------------------------------------
module mul_iter_counter #(
   parameter int unsigned CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mul_sequencer.sv
// -----------------------------------------------------------------------------
// mul_sequencer
// Multi-cycle controller for the H6 shift-add multiplier. Sequences the load
// (MUL1), iterate (MUL2) and flag/result (MUL3) phases, drives the H6 A/Q
// strobes and stalls the control FSM while a multiply is in flight.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       MUL decoded in EX0; only sampled in IDLE
//   abort       flush request; beats everything, including start
//   q0          H6 multiplier LSB (H6_q_out[0])
//   h6_load     A<=0, Q<=multiplier, M<=multiplicand, C<=0
//   h6_add      A<=A+M this cycle (combinational from q0)
//   h6_shift    shift {C,A,Q} right one bit this cycle
//   MUL1/2/3    phase indicators (load / iterate / flag)
//   busy        stall to the control FSM, LOAD through FLAG
//   done        one-cycle pulse coincident with MUL3
//   h6_sub      (MUL_SIGNED_BOOTH_EN only) A<=A-M this cycle
//   h6_arith    (MUL_SIGNED_BOOTH_EN only) shift is arithmetic; tied high
//
// Build option: define MUL_SIGNED_BOOTH_EN for radix-2 Booth (signed) recoding.
// -----------------------------------------------------------------------------
module mul_sequencer
   import mul_sequencer_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic abort,
   input  logic q0,
   output logic h6_load,
   output logic h6_add,
   output logic h6_shift,
   output logic MUL1,
   output logic MUL2,
   output logic MUL3,
   output logic busy,
`ifdef MUL_SIGNED_BOOTH_EN
   output logic h6_sub,
   output logic h6_arith,
`endif
   output logic done
);

   if ((2 ** CNT_W) <= WIDTH) begin : g_bad_cnt_w
      $error("mul_sequencer: CNT_W too narrow for WIDTH");
   end

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   state_e state_q, state_d;
   logic   mul1_q, mul2_q, mul3_q, busy_q;
   logic   cnt_zero;

   // Abort wins in every state, including IDLE with start pending.
   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: if (start) state_d = LOAD;
            LOAD: state_d = ITER;
            ITER: if (cnt_zero) state_d = FLAG;
            FLAG: state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Phase outputs are registered from the next state, so they equal a decode
   // of state_q without any combinational path after the flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         mul1_q  <= 1'b0;
         mul2_q  <= 1'b0;
         mul3_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mul1_q  <= (state_d == LOAD);
         mul2_q  <= (state_d == ITER);
         mul3_q  <= (state_d == FLAG);
         busy_q  <= (state_d != IDLE);
      end
   end

   // Counter holds WIDTH-1 on the first iterate cycle and reaches zero on the
   // last, giving exactly WIDTH iterate cycles.
   mul_iter_counter #(
      .CNT_W (CNT_W)
   ) u_iter_counter (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_i      (abort),
      .load_i     (state_q == LOAD),
      .load_val_i (LAST_ITER),
      .dec_i      (state_q == ITER),
      .zero_o     (cnt_zero)
   );

   assign MUL1     = mul1_q;
   assign MUL2     = mul2_q;
   assign MUL3     = mul3_q;
   assign done     = mul3_q;
   assign busy     = busy_q;
   assign h6_load  = mul1_q;
   assign h6_shift = mul2_q;

`ifdef MUL_SIGNED_BOOTH_EN
   // q_m1 is the multiplier bit shifted out on the previous iterate cycle;
   // together with q0 it forms the Booth pair.
   logic q_m1_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_m1_q <= 1'b0;
      end else if (abort || (state_q == LOAD)) begin
         q_m1_q <= 1'b0;
      end else if (state_q == ITER) begin
         q_m1_q <= q0;
      end
   end

   assign h6_sub   = mul2_q &  q0 & ~q_m1_q;  // pair 10
   assign h6_add   = mul2_q & ~q0 &  q_m1_q;  // pair 01
   assign h6_arith = 1'b1;
`else
   // Mealy on q0: H6 adds and shifts in the same cycle.
   assign h6_add = mul2_q & q0;
`endif

endmodule

// File: tb/tb_mul_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mul_sequencer
// Self-checking bench for mul_sequencer. A behavioural H6 datapath supplies q0;
// products are checked against plain arithmetic, and strobe patterns against
// the multiplier bits. Define MUL_SIGNED_BOOTH_EN to check the Booth build.
// -----------------------------------------------------------------------------
module tb_mul_sequencer;

   localparam int WIN = 22;  // observation window per multiply (cycles)

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic abort = 1'b0;
   logic q0;
   logic h6_load, h6_add, h6_shift, MUL1, MUL2, MUL3, busy, done;
`ifdef MUL_SIGNED_BOOTH_EN
   logic h6_sub, h6_arith;
`else
   logic h6_sub;
   assign h6_sub = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mul_sequencer dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .abort    (abort),
      .q0       (q0),
      .h6_load  (h6_load),
      .h6_add   (h6_add),
      .h6_shift (h6_shift),
      .MUL1     (MUL1),
      .MUL2     (MUL2),
      .MUL3     (MUL3),
      .busy     (busy),
`ifdef MUL_SIGNED_BOOTH_EN
      .h6_sub   (h6_sub),
      .h6_arith (h6_arith),
`endif
      .done     (done)
   );

   // ---------------- behavioural H6 datapath ----------------
   logic [15:0] op_m = '0, op_q = '0;
   logic [15:0] m_a = '0, m_q = '0, m_m = '0;

   assign q0 = m_q[0];

`ifdef MUL_SIGNED_BOOTH_EN
   logic [15:0] s_nx;
   always_comb s_nx = h6_sub ? (m_a - m_m) : (h6_add ? (m_a + m_m) : m_a);
   always @(posedge clk) begin
      if (h6_load) begin
         m_a <= '0; m_q <= op_q; m_m <= op_m;
      end else if (h6_shift) begin
         m_a <= {s_nx[15], s_nx[15:1]};
         m_q <= {s_nx[0], m_q[15:1]};
      end
   end
`else
   logic [16:0] s_nx;
   always_comb s_nx = {1'b0, m_a} + (h6_add ? {1'b0, m_m} : 17'd0);
   always @(posedge clk) begin
      if (h6_load) begin
         m_a <= '0; m_q <= op_q; m_m <= op_m;
      end else if (h6_shift) begin
         m_a <= s_nx[16:1];
         m_q <= {s_nx[0], m_q[15:1]};
      end
   end
`endif

   // ---------------- observations from one run ----------------
   int          n_mul1, k_mul1, n_mul2, n_mul3, k_mul3, n_busy, k_busy_last;
   int          n_bad_strobe, n_iter;
   logic [15:0] add_vec, sub_vec;
   logic [31:0] res;

   // Pulse start, then watch WIN cycles. k=1 is the cycle after the start edge.
   // start is re-driven high for k in [hold_lo,hold_hi]; abort at k==abort_k.
   task automatic run_mul(input logic [15:0] mc, input logic [15:0] mp,
                          input int abort_k, input int hold_lo, input int hold_hi);
      op_m = mc; op_q = mp;
      n_mul1 = 0; k_mul1 = -1; n_mul2 = 0; n_mul3 = 0; k_mul3 = -1;
      n_busy = 0; k_busy_last = -1; n_bad_strobe = 0; n_iter = 0;
      add_vec = '0; sub_vec = '0; res = 'x;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 1; k <= WIN; k++) begin
         @(negedge clk);
         if (MUL1) begin n_mul1++; if (k_mul1 < 0) k_mul1 = k; end
         if (MUL2) begin
            if (n_iter < 16) begin
               add_vec[n_iter] = h6_add;
               sub_vec[n_iter] = h6_sub;
            end
            n_iter++;
            n_mul2++;
         end
         if (MUL3) begin n_mul3++; k_mul3 = k; res = {m_a, m_q}; end
         if (busy) begin n_busy++; k_busy_last = k; end
         if ((done !== MUL3) || (h6_load !== MUL1) || (h6_shift !== MUL2) ||
             (!MUL2 && (h6_add || h6_sub)))
            n_bad_strobe++;
         start = (k >= hold_lo) && (k <= hold_hi);
         abort = (k == abort_k);
      end
      start = 1'b0;
      abort = 1'b0;
   endtask

   // Full, unaborted multiply: timing, strobe pattern and product.
   task automatic check_full(input string tag, input logic [15:0] mc,
                             input logic [15:0] mp);
      logic [31:0] exp_res;
      logic [15:0] exp_add, exp_sub;
`ifdef MUL_SIGNED_BOOTH_EN
      logic prev;
      exp_res = 32'($signed(mc) * $signed(mp));
      prev = 1'b0;
      for (int i = 0; i < 16; i++) begin
         exp_add[i] = ~mp[i] & prev;
         exp_sub[i] = mp[i] & ~prev;
         prev = mp[i];
      end
`else
      exp_res = {16'd0, mc} * {16'd0, mp};
      exp_add = mp;
      exp_sub = '0;
`endif
      checks++;
      if (n_mul1 !== 1 || k_mul1 !== 1) begin
         errors++; $display("FAIL %s mul1: count %0d at k=%0d, want 1 at k=1", tag, n_mul1, k_mul1);
      end
      checks++;
      if (n_mul2 !== 16) begin
         errors++; $display("FAIL %s mul2: %0d cycles, want 16", tag, n_mul2);
      end
      checks++;
      if (n_mul3 !== 1 || k_mul3 !== 18) begin
         errors++; $display("FAIL %s mul3: count %0d at k=%0d, want 1 at k=18", tag, n_mul3, k_mul3);
      end
      checks++;
      if (n_busy !== 18 || k_busy_last !== 18) begin
         errors++; $display("FAIL %s busy: %0d cycles last k=%0d, want 18 last k=18", tag, n_busy, k_busy_last);
      end
      checks++;
      if (add_vec !== exp_add || sub_vec !== exp_sub) begin
         errors++; $display("FAIL %s strobes: add=%h sub=%h, want add=%h sub=%h", tag, add_vec, sub_vec, exp_add, exp_sub);
      end
      checks++;
      if (n_bad_strobe !== 0) begin
         errors++; $display("FAIL %s strobe_decode: %0d bad cycles, want 0", tag, n_bad_strobe);
      end
      checks++;
      if (res !== exp_res) begin
         errors++; $display("FAIL %s product: got %h, want %h", tag, res, exp_res);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      #12 rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({h6_load, h6_add, h6_shift, MUL1, MUL2, MUL3, busy, done} !== 8'h00) begin
         errors++; $display("FAIL reset_outputs: %b, want 00000000",
                            {h6_load, h6_add, h6_shift, MUL1, MUL2, MUL3, busy, done});
      end
      // Reset mid-multiply: outputs drop before any clock edge.
      op_m = 16'h1234; op_q = 16'hFFFF;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (6) @(posedge clk);
      #3;
      checks++;
      if (busy !== 1'b1 || MUL2 !== 1'b1) begin
         errors++; $display("FAIL pre_reset_busy: busy=%b mul2=%b, want 1 1", busy, MUL2);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({h6_load, h6_add, h6_shift, MUL1, MUL2, MUL3, busy, done} !== 8'h00) begin
         errors++; $display("FAIL async_reset: %b, want 00000000",
                            {h6_load, h6_add, h6_shift, MUL1, MUL2, MUL3, busy, done});
      end
      @(negedge clk);
      rst_n = 1'b1;
      begin
         int n_b;
         n_b = 0;
         for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (busy) n_b++;
         end
         checks++;
         if (n_b !== 0) begin
            errors++; $display("FAIL idle_busy: busy high %0d cycles, want 0", n_b);
         end
      end
   endtask

   task automatic test_directed();
`ifdef MUL_SIGNED_BOOTH_EN
      run_mul(16'hFFFD, 16'h0005, 0, 0, 0);
      check_full("booth_m3x5", 16'hFFFD, 16'h0005);
      checks++;
      if (res !== 32'hFFFF_FFF1) begin
         errors++; $display("FAIL booth_m3x5_const: got %h, want FFFFFFF1", res);
      end
      checks++;
      if (h6_arith !== 1'b1) begin
         errors++; $display("FAIL h6_arith: got %b, want 1", h6_arith);
      end
`else
      run_mul(16'h0003, 16'h0005, 0, 0, 0);
      check_full("mul_3x5", 16'h0003, 16'h0005);
      checks++;
      if (res !== 32'h0000_000F || add_vec !== 16'h0005) begin
         errors++; $display("FAIL mul_3x5_const: res=%h add=%h, want 0000000F 0005", res, add_vec);
      end
      run_mul(16'hFFFF, 16'hFFFF, 0, 0, 0);
      check_full("mul_ffff", 16'hFFFF, 16'hFFFF);
      checks++;
      if (res !== 32'hFFFE_0001 || add_vec !== 16'hFFFF) begin
         errors++; $display("FAIL mul_ffff_const: res=%h add=%h, want FFFE0001 FFFF", res, add_vec);
      end
`endif
   endtask

   task automatic test_abort();
      // 5th ITER cycle is k=6; IDLE from k=7.
      run_mul(16'h00A5, 16'h7777, 6, 0, 0);
      checks++;
      if (n_busy !== 6 || k_busy_last !== 6) begin
         errors++; $display("FAIL abort_busy: %0d cycles last k=%0d, want 6 last k=6", n_busy, k_busy_last);
      end
      checks++;
      if (n_mul3 !== 0 || n_mul2 !== 5) begin
         errors++; $display("FAIL abort_phases: mul3=%0d mul2=%0d, want 0 5", n_mul3, n_mul2);
      end
      run_mul(16'h0011, 16'h0203, 0, 0, 0);
      check_full("after_abort", 16'h0011, 16'h0203);
   endtask

   task automatic test_ignored_start();
      // start re-asserted while busy (k=3..10) must not queue a second multiply.
      run_mul(16'h0101, 16'h0033, 0, 3, 10);
      check_full("start_busy", 16'h0101, 16'h0033);
      // start together with abort in IDLE: stay idle.
      begin
         int n_b;
         n_b = 0;
         @(negedge clk);
         start = 1'b1; abort = 1'b1;
         @(negedge clk);
         start = 1'b0; abort = 1'b0;
         for (int k = 0; k < 4; k++) begin
            if (busy || MUL1) n_b++;
            @(negedge clk);
         end
         checks++;
         if (n_b !== 0) begin
            errors++; $display("FAIL start_abort_idle: busy %0d cycles, want 0", n_b);
         end
      end
   endtask

   task automatic test_back_to_back();
      // start held high: FLAG at k=18, one dead IDLE at k=19, LOAD at k=20.
      int n_l, k_second, b19;
      n_l = 0; k_second = -1; b19 = -1;
      op_m = 16'h0002; op_q = 16'h0002;
      @(negedge clk);
      start = 1'b1;
      for (int k = 1; k <= 24; k++) begin
         @(negedge clk);
         if (MUL1) begin n_l++; if (k > 1) k_second = k; end
         if (k == 19) b19 = int'(busy);
      end
      start = 1'b0;
      checks++;
      if (n_l !== 2 || k_second !== 20 || b19 !== 0) begin
         errors++; $display("FAIL back_to_back: loads=%0d second_k=%0d busy19=%0d, want 2 20 0",
                            n_l, k_second, b19);
      end
      // Let the second multiply drain.
      for (int k = 0; k < 40 && busy; k++) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL b2b_drain: busy=%b, want 0", busy);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 6; n++) begin
         logic [15:0] a, b;
         a = 16'($urandom);
         b = 16'($urandom);
         run_mul(a, b, 0, 0, 0);
         check_full($sformatf("rand%0d", n), a, b);
      end
      for (int n = 0; n < 3; n++) begin
         int ak;
         ak = int'($urandom_range(2, 17));
         run_mul(16'($urandom), 16'($urandom), ak, 0, 0);
         checks++;
         if (n_busy !== ak || n_mul3 !== 0) begin
            errors++; $display("FAIL rand_abort%0d: busy=%0d mul3=%0d, want %0d 0", n, n_busy, n_mul3, ak);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_abort();
      test_ignored_start();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Hard time limit so the run always terminates.
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
